ic_prio_ctrl: RTL and testbench

- Parametrised next-generation interrupt controller.
- Collects N_IRQ peripheral requests, with per-source edge or level mode, mask and programmable priority.
- Arbitrates the eligible pending sources and presents a single irq_out/irq_id to the processor.
- Tracks the ack → service → end-of-interrupt handshake. Sits between the peripherals and the processor core.

---
 rtl/ic_pkg.sv | 24 ++
 rtl/ic_prio_ctrl_if.sv | 42 ++++
 rtl/ic_prio_ctrl_arbiter.sv | 36 +++
 rtl/ic_prio_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ic_prio_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ic_pkg.sv
// ic_pkg: shared types and constants for the ic_prio_ctrl interrupt controller.
// Holds the FSM state enum, the interrupt-ID width helper and default parameters.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } ic_state_e;

    localparam int unsigned IC_N_IRQ_DEF       = 32'd8;
    localparam int unsigned IC_PRIO_W_DEF      = 32'd3;
    localparam int unsigned IC_ACK_TIMEOUT_DEF = 32'd16;

    // Width of an interrupt ID: clog2(n), never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/ic_prio_ctrl_if.sv
// ic_prio_ctrl_if: peripheral and processor-side signals of the interrupt controller.
// The ack_timeout pulse exists only when IC_ACK_TIMEOUT_EN is defined.
interface ic_prio_ctrl_if
    import ic_pkg::*;
#(
    parameter int unsigned N_IRQ  = IC_N_IRQ_DEF,
    parameter int unsigned PRIO_W = IC_PRIO_W_DEF
);
    localparam int unsigned ID_W = id_width(N_IRQ);

    logic [N_IRQ-1:0]        irq_requests;
    logic [N_IRQ-1:0]        mask_reg;
    logic [N_IRQ-1:0]        edge_mode;
    logic [N_IRQ*PRIO_W-1:0] prio_cfg;
    logic                    ack;
    logic                    eoi;
    logic                    irq_out;
    logic [ID_W-1:0]         irq_id;
    logic [N_IRQ-1:0]        pending_reg;
    logic [N_IRQ-1:0]        in_service;
    logic                    busy;
`ifdef IC_ACK_TIMEOUT_EN
    logic                    ack_timeout;
`endif

    modport slave (
        input  irq_requests, mask_reg, edge_mode, prio_cfg, ack, eoi,
        output irq_out, irq_id, pending_reg, in_service, busy
`ifdef IC_ACK_TIMEOUT_EN
        , output ack_timeout
`endif
    );

    modport master (
        output irq_requests, mask_reg, edge_mode, prio_cfg, ack, eoi,
        input  irq_out, irq_id, pending_reg, in_service, busy
`ifdef IC_ACK_TIMEOUT_EN
        , input ack_timeout
`endif
    );

endinterface

// File: rtl/ic_prio_ctrl_arbiter.sv
// ic_prio_arbiter: combinational selector picking the eligible source with the
// highest unsigned priority; equal priorities resolve to the lowest index.
module ic_prio_arbiter #(
    parameter int unsigned N_IRQ  = 32'd8,
    parameter int unsigned PRIO_W = 32'd3,
    parameter int unsigned ID_W   = 32'd3
) (
    input  logic [N_IRQ-1:0]        eligible_i,
    input  logic [N_IRQ*PRIO_W-1:0] prio_cfg_i,
    output logic [ID_W-1:0]         win_id_o,
    output logic                    win_vld_o
);

    logic [PRIO_W-1:0] best_prio_s;
    logic [ID_W-1:0]   best_id_s;
    logic              found_s;

    // Ascending scan with strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_prio_s = '0;
        best_id_s   = '0;
        found_s     = 1'b0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (eligible_i[i] && (!found_s || (prio_cfg_i[i*PRIO_W +: PRIO_W] > best_prio_s))) begin
                best_prio_s = prio_cfg_i[i*PRIO_W +: PRIO_W];
                best_id_s   = ID_W'(i);
                found_s     = 1'b1;
            end else begin
                best_prio_s = best_prio_s;
            end
        end
        win_id_o  = best_id_s;
        win_vld_o = found_s;
    end

endmodule

// File: rtl/ic_prio_ctrl.sv
// ic_prio_ctrl: prioritised interrupt controller. Latches edge/level requests,
// arbitrates masked pending sources in IDLE, and tracks ack -> service -> eoi.
// Optional macro IC_ACK_TIMEOUT_EN: withdraws an unacknowledged interrupt after
// ACK_TIMEOUT cycles in ASSERT and pulses ack_timeout.
module ic_prio_ctrl
    import ic_pkg::*;
#(
    parameter int unsigned N_IRQ  = IC_N_IRQ_DEF,
    parameter int unsigned PRIO_W = IC_PRIO_W_DEF
`ifdef IC_ACK_TIMEOUT_EN
    , parameter int unsigned ACK_TIMEOUT = IC_ACK_TIMEOUT_DEF
`endif
) (
    input logic           clk,
    input logic           rst,
    ic_prio_ctrl_if.slave bus
);

    localparam int unsigned ID_W = id_width(N_IRQ);

    ic_state_e        state_q, state_d;
    logic             irq_out_q, irq_out_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic             busy_q, busy_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] prev_req_q;
    logic [N_IRQ-1:0] eligible_s;
    logic [ID_W-1:0]  win_id_s;
    logic             win_vld_s;
    logic             withdraw_s;
    logic             ack_take_s;
    logic [N_IRQ-1:0] ack_clr_s;
    logic             tmo_s;

    assign eligible_s = (state_q == IDLE) ? (pending_q & bus.mask_reg) : '0;

    ic_prio_arbiter #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_arb (
        .eligible_i (eligible_s),
        .prio_cfg_i (bus.prio_cfg),
        .win_id_o   (win_id_s),
        .win_vld_o  (win_vld_s)
    );

    // Decide withdrawal vs. acceptance of ack while asserting; withdrawal wins.
    always_comb begin
        withdraw_s = 1'b0;
        ack_take_s = 1'b0;
        ack_clr_s  = '0;
        if (state_q == ASSERT) begin
            if (!bus.mask_reg[irq_id_q] ||
                (!bus.edge_mode[irq_id_q] && !pending_q[irq_id_q])) begin
                withdraw_s = 1'b1;
            end else if (bus.ack) begin
                ack_take_s = 1'b1;
                ack_clr_s  = {{(N_IRQ-1){1'b0}}, 1'b1} << irq_id_q;
            end else begin
                ack_take_s = 1'b0;
            end
        end else begin
            withdraw_s = 1'b0;
        end
    end

    // Pending update: edge sources set on 0->1 (set beats ack clear), level sources follow input.
    always_comb begin
        pending_d = (bus.edge_mode & ((bus.irq_requests & ~prev_req_q) | (pending_q & ~ack_clr_s)))
                  | (~bus.edge_mode & bus.irq_requests);
    end

`ifdef IC_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_timeout_q;

    // Count ASSERT cycles; the counter is zero on the first ASSERT cycle.
    always_comb begin
        if (state_q == ASSERT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        tmo_s = (state_q == ASSERT) && !withdraw_s && !ack_take_s &&
                (cnt_q == CNT_W'(ACK_TIMEOUT - 32'd1));
    end

    // Timeout counter and one-cycle withdrawal pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ack_timeout_q <= tmo_s;
        end
    end

    assign bus.ack_timeout = ack_timeout_q;
`else
    assign tmo_s = 1'b0;
`endif

    // FSM next-state and registered output values.
    always_comb begin
        state_d      = state_q;
        irq_out_d    = irq_out_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (win_vld_s) begin
                    state_d   = ASSERT;
                    irq_out_d = 1'b1;
                    irq_id_d  = win_id_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ASSERT: begin
                if (withdraw_s || tmo_s) begin
                    state_d   = IDLE;
                    irq_out_d = 1'b0;
                end else if (ack_take_s) begin
                    state_d      = SERVICE;
                    irq_out_d    = 1'b0;
                    in_service_d = ack_clr_s;
                    busy_d       = 1'b1;
                end else begin
                    state_d = ASSERT;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    state_d      = IDLE;
                    in_service_d = '0;
                    busy_d       = 1'b0;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d      = IDLE;
                irq_out_d    = 1'b0;
                in_service_d = '0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State, outputs, pending and previous-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_out_q    <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= '0;
            busy_q       <= 1'b0;
            pending_q    <= '0;
            prev_req_q   <= '0;
        end else begin
            state_q      <= state_d;
            irq_out_q    <= irq_out_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            prev_req_q   <= bus.irq_requests;
        end
    end

    assign bus.irq_out     = irq_out_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.in_service  = in_service_q;
    assign bus.busy        = busy_q;
    assign bus.pending_reg = pending_q;

endmodule

// File: tb/tb_ic_prio_ctrl.sv
// tb_ic_prio_ctrl: directed scenarios plus randomized traffic for ic_prio_ctrl,
// compared every cycle against a behavioural model of the controller.
module tb_ic_prio_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ic_prio_ctrl_if #(.N_IRQ(8), .PRIO_W(3)) bus ();

    ic_prio_ctrl #(.N_IRQ(8), .PRIO_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int       m_state;   // 0 idle, 1 asserting, 2 servicing
    bit       m_out;
    int       m_id;
    bit [7:0] m_pend;
    bit [7:0] m_prev;
    bit [7:0] m_insvc;
    bit       m_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Highest priority value first, lowest index within a priority level.
    function automatic int pick_winner(input bit [7:0] el, input bit [23:0] pc);
        for (int p = 7; p >= 0; p--) begin
            for (int i = 0; i < 8; i++) begin
                if (el[i] && (int'(pc[i*3 +: 3]) == p)) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        bit [7:0] req, msk, edg;
        bit       acked;
        int       win;
        req   = bus.irq_requests;
        msk   = bus.mask_reg;
        edg   = bus.edge_mode;
        acked = 1'b0;
        if (rst) begin
            m_state = 0; m_out = 1'b0; m_id = 0;
            m_pend = 8'h00; m_prev = 8'h00; m_insvc = 8'h00; m_busy = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    win = pick_winner(m_pend & msk, bus.prio_cfg);
                    if (win >= 0) begin
                        m_state = 1; m_out = 1'b1; m_id = win;
                    end
                end
                1: begin
                    if (!msk[m_id] || (!edg[m_id] && !m_pend[m_id])) begin
                        m_state = 0; m_out = 1'b0;
                    end else if (bus.ack) begin
                        m_state = 2; m_out = 1'b0; m_busy = 1'b1;
                        m_insvc = 8'h01 << m_id;
                        acked = 1'b1;
                    end
                end
                default: begin
                    if (bus.eoi) begin
                        m_state = 0; m_insvc = 8'h00; m_busy = 1'b0;
                    end
                end
            endcase
            for (int i = 0; i < 8; i++) begin
                if (edg[i]) begin
                    if (req[i] && !m_prev[i]) m_pend[i] = 1'b1;
                    else if (acked && (i == m_id)) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = req[i];
                end
            end
            m_prev = req;
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("irq_out",    64'(bus.irq_out),     64'(m_out));
        check_eq("irq_id",     64'(bus.irq_id),      64'(m_id));
        check_eq("pending",    64'(bus.pending_reg), 64'(m_pend));
        check_eq("in_service", 64'(bus.in_service),  64'(m_insvc));
        check_eq("busy",       64'(bus.busy),        64'(m_busy));
    endtask

    task automatic serve();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_state = 0; m_out = 1'b0; m_id = 0;
        m_pend = 8'h00; m_prev = 8'h00; m_insvc = 8'h00; m_busy = 1'b0;
        rst = 1'b1;
        bus.irq_requests = 8'h00;
        bus.mask_reg     = 8'hFF;
        bus.edge_mode    = 8'hFF;
        bus.prio_cfg     = 24'h0;
        bus.ack          = 1'b0;
        bus.eoi          = 1'b0;
        tick(); tick();
        check_eq("rst_irq_out", 64'(bus.irq_out), 64'd0);
        check_eq("rst_pending", 64'(bus.pending_reg), 64'd0);
        rst = 1'b0;
        tick();

        // Edge source 3: pending next edge, irq_out one edge later
        bus.irq_requests = 8'h08;
        tick();
        check_eq("s1_pending", 64'(bus.pending_reg), 64'h08);
        check_eq("s1_out_lo",  64'(bus.irq_out), 64'd0);
        tick();
        check_eq("s1_out_hi",  64'(bus.irq_out), 64'd1);
        check_eq("s1_id",      64'(bus.irq_id), 64'd3);
        bus.irq_requests = 8'h00;
        serve();

        // Sources 1 (prio 2) and 5 (prio 6)
        bus.prio_cfg = (24'd2 << 3) | (24'd6 << 15);
        bus.irq_requests = 8'h22;
        tick(); tick();
        check_eq("s2_id5", 64'(bus.irq_id), 64'd5);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check_eq("s2_insvc5", 64'(bus.in_service), 64'h20);
        check_eq("s2_busy",   64'(bus.busy), 64'd1);
        bus.irq_requests = 8'h00;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();
        check_eq("s2_out1", 64'(bus.irq_out), 64'd1);
        check_eq("s2_id1",  64'(bus.irq_id), 64'd1);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check_eq("s2_insvc1", 64'(bus.in_service), 64'h02);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;

        // Equal priority 4 on sources 2 and 6
        bus.prio_cfg = (24'd4 << 6) | (24'd4 << 18);
        bus.irq_requests = 8'h44;
        tick(); tick();
        check_eq("s3_tie_id", 64'(bus.irq_id), 64'd2);
        serve();
        tick();
        check_eq("s3_next_id", 64'(bus.irq_id), 64'd6);
        serve();

        // Masked source 4
        bus.mask_reg = 8'hEF;
        bus.irq_requests = 8'h10;
        tick(); tick(); tick();
        check_eq("s4_masked_out", 64'(bus.irq_out), 64'd0);
        bus.mask_reg = 8'hFF;
        tick();
        check_eq("s4_out", 64'(bus.irq_out), 64'd1);
        check_eq("s4_id",  64'(bus.irq_id), 64'd4);
        serve();
        bus.irq_requests = 8'h00;
        tick();

        // Level source 0 drops during ASSERT
        bus.edge_mode = 8'hFE;
        bus.irq_requests = 8'h01;
        tick(); tick();
        check_eq("s5_out", 64'(bus.irq_out), 64'd1);
        bus.irq_requests = 8'h00;
        tick(); tick();
        check_eq("s5_withdrawn", 64'(bus.irq_out), 64'd0);
        check_eq("s5_pend0",     64'(bus.pending_reg[0]), 64'd0);
        bus.edge_mode = 8'hFF;
        tick();

        // Reset during SERVICE with source 0 held high
        bus.irq_requests = 8'h01;
        tick(); tick();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check_eq("s6_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("s6_rst_busy",  64'(bus.busy), 64'd0);
        check_eq("s6_rst_insvc", 64'(bus.in_service), 64'd0);
        rst = 1'b0;
        tick(); tick();
        check_eq("s6_repend_out", 64'(bus.irq_out), 64'd1);
        serve();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            bus.irq_requests = 8'($urandom);
            bus.mask_reg     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 40) == 0) bus.edge_mode = 8'($urandom);
            if ($urandom_range(0, 20) == 0) bus.prio_cfg = 24'($urandom);
            bus.ack = ($urandom_range(0, 2) == 0);
            bus.eoi = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst = 1'b0;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
